ifu_ifetch_pf: RTL and testbench

//  Next-generation IFU fetch stage with a prefetch buffer. Issues in-order sequential RV32 fetches on the
//  ifu_req channel with up to OTF_DEPTH outstanding, and queues responses in an IBUF_DEPTH instruction buffer.

---
 rtl/ifu_ifetch_pf_pkg.sv | 15 +
 rtl/ifu_ifetch_pf_ibuf.sv | 50 +++++
 rtl/ifu_ifetch_pf.sv | 136 +++++++++++++
 tb/tb_ifu_ifetch_pf.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_ifetch_pf_pkg.sv
// Shared constants and helpers for the IFU prefetch fetch stage.
// Widths follow the core's PC and instruction sizes.
package ifu_ifetch_pf_pkg;

   localparam int PC_SIZE         = 32;
   localparam int INSTR_SIZE      = 32;
   localparam int OTF_DEPTH_DFLT  = 2;
   localparam int IBUF_DEPTH_DFLT = 4;

   // RV32 fetch targets must be word aligned.
   function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
      return pc_lsb != 2'b00;
   endfunction

endpackage

// File: rtl/ifu_ifetch_pf_ibuf.sv
// Instruction buffer: synchronous FIFO with a clear that empties it in one cycle.
// Clear has priority over a same-cycle push or pop.
module ifu_ibuf #(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic                         pop_i,
   input  logic                         clr_i,
   input  logic [DW-1:0]                wdata_i,
   output logic [DW-1:0]                rdata_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH+1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
   logic [CW-1:0] cnt_q;

   assign wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + AW'(1);
   assign rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + AW'(1);

   always_ff @(posedge clk) begin
      if (!rst_n || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_d;
         if (pop_i)  rd_ptr_q <= rd_ptr_d;
         cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_i && !clr_i) mem_q[wr_ptr_q] <= wdata_i;
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign cnt_o   = cnt_q;

endmodule

// File: rtl/ifu_ifetch_pf.sv
// IFU fetch stage: sequential prefetch with credit-limited outstanding requests,
// an instruction buffer, flush with in-flight drop, halt, and misaligned-target marker.
module ifu_ifetch_pf
   import ifu_ifetch_pf_pkg::*;
#(
   parameter int PC_W       = PC_SIZE,
   parameter int INSTR_W    = INSTR_SIZE,
   parameter int OTF_DEPTH  = OTF_DEPTH_DFLT,
   parameter int IBUF_DEPTH = IBUF_DEPTH_DFLT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [PC_W-1:0]    pc_rtvec,
   output logic               ifu_req_valid,
   input  logic               ifu_req_ready,
   output logic [PC_W-1:0]    ifu_req_pc,
   output logic               ifu_req_seq,
   output logic [PC_W-1:0]    ifu_req_last_pc,
   input  logic               ifu_rsp_valid,
   output logic               ifu_rsp_ready,
   input  logic               ifu_rsp_err,
   input  logic [INSTR_W-1:0] ifu_rsp_instr,
   output logic [INSTR_W-1:0] ifu_o_ir,
   output logic [PC_W-1:0]    ifu_o_pc,
   output logic               ifu_o_buserr,
   output logic               ifu_o_misalgn,
   output logic               ifu_o_valid,
   input  logic               ifu_o_ready,
   input  logic               pipe_flush_req,
   output logic               pipe_flush_ack,
   input  logic [PC_W-1:0]    pipe_flush_add_op1,
   input  logic [PC_W-1:0]    pipe_flush_add_op2,
   input  logic               ifu_halt_req,
   output logic               ifu_halt_ack
);

   localparam int CW = $clog2(OTF_DEPTH+1);
   localparam int BW = $clog2(IBUF_DEPTH+1);
   localparam int SW = BW + 1;
   localparam int EW = INSTR_W + PC_W + 2;

   logic              reset_flag_q, first_q, marker_done_q, halt_ack_q;
   logic [PC_W-1:0]   next_pc_q, last_pc_q, rsp_pc_q, flush_tgt;
   logic [CW-1:0]     otf_cnt_q, otf_cnt_d, drop_cnt_q, drop_cnt_d;
   logic [SW-1:0]     inflight;
   logic              room, misalgn, req_hsk, rsp_hsk, rsp_push, mis_push;
   logic              ib_push, ib_pop, ib_full, ib_empty;
   logic [BW-1:0]     ib_cnt;
   logic [EW-1:0]     ib_wdata, ib_rdata;

   assign flush_tgt = pipe_flush_add_op1 + pipe_flush_add_op2;
   assign misalgn   = pc_misaligned(next_pc_q[1:0]);

   // Credits: every outstanding request owns a buffer slot, so responses are never refused.
   assign inflight = SW'(otf_cnt_q) + SW'(ib_cnt);
   assign room     = (otf_cnt_q < CW'(OTF_DEPTH)) && (inflight < SW'(IBUF_DEPTH));

   assign ifu_req_valid   = ~reset_flag_q & ~ifu_halt_req & ~pipe_flush_req & ~misalgn & room;
   assign ifu_req_pc      = next_pc_q;
   assign ifu_req_seq     = ~first_q;
   assign ifu_req_last_pc = last_pc_q;
   assign ifu_rsp_ready   = ~reset_flag_q;
   assign pipe_flush_ack  = 1'b1;
   assign ifu_halt_ack    = halt_ack_q;

   assign req_hsk  = ifu_req_valid & ifu_req_ready;
   assign rsp_hsk  = ifu_rsp_valid & ifu_rsp_ready;
   assign rsp_push = rsp_hsk & (drop_cnt_q == '0) & ~pipe_flush_req;
   assign mis_push = misalgn & ~marker_done_q & ~reset_flag_q & ~pipe_flush_req
                   & (drop_cnt_q == '0) & (otf_cnt_q == '0) & ~ib_full;

   assign ib_push  = rsp_push | mis_push;
   assign ib_wdata = mis_push ? {{INSTR_W{1'b0}}, next_pc_q, 1'b0, 1'b1}
                              : {ifu_rsp_instr, rsp_pc_q, ifu_rsp_err, 1'b0};
   assign ib_pop   = ifu_o_valid & ifu_o_ready;

   always_comb begin
      otf_cnt_d  = otf_cnt_q + CW'(req_hsk) - CW'(rsp_hsk);
      drop_cnt_d = drop_cnt_q;
      if (pipe_flush_req)                    drop_cnt_d = otf_cnt_q - CW'(rsp_hsk);
      else if (rsp_hsk && drop_cnt_q != '0)  drop_cnt_d = drop_cnt_q - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         reset_flag_q  <= 1'b1;
         first_q       <= 1'b1;
         marker_done_q <= 1'b0;
         halt_ack_q    <= 1'b0;
         next_pc_q     <= '0;
         last_pc_q     <= '0;
         rsp_pc_q      <= '0;
         otf_cnt_q     <= '0;
         drop_cnt_q    <= '0;
      end else begin
         reset_flag_q <= 1'b0;
         otf_cnt_q    <= otf_cnt_d;
         drop_cnt_q   <= drop_cnt_d;
         halt_ack_q   <= ifu_halt_req & (otf_cnt_q == '0) & (drop_cnt_q == '0);
         if (reset_flag_q || pipe_flush_req) begin
            next_pc_q     <= reset_flag_q ? pc_rtvec : flush_tgt;
            rsp_pc_q      <= reset_flag_q ? pc_rtvec : flush_tgt;
            first_q       <= 1'b1;
            marker_done_q <= 1'b0;
         end else begin
            if (req_hsk) begin
               next_pc_q <= next_pc_q + PC_W'(4);
               last_pc_q <= next_pc_q;
               first_q   <= 1'b0;
            end
            if (rsp_push) rsp_pc_q <= rsp_pc_q + PC_W'(4);
            if (mis_push) marker_done_q <= 1'b1;
         end
      end
   end

   ifu_ibuf #(.DW(EW), .DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (ib_push),
      .pop_i   (ib_pop),
      .clr_i   (pipe_flush_req),
      .wdata_i (ib_wdata),
      .rdata_o (ib_rdata),
      .full_o  (ib_full),
      .empty_o (ib_empty),
      .cnt_o   (ib_cnt)
   );

   assign ifu_o_valid   = ~ib_empty & ~pipe_flush_req;
   assign ifu_o_ir      = ib_empty ? '0 : ib_rdata[EW-1 -: INSTR_W];
   assign ifu_o_pc      = ib_empty ? '0 : ib_rdata[PC_W+1 -: PC_W];
   assign ifu_o_buserr  = ~ib_empty & ib_rdata[1];
   assign ifu_o_misalgn = ~ib_empty & ib_rdata[0];

endmodule

// File: tb/tb_ifu_ifetch_pf.sv
// Directed bench for ifu_ifetch_pf: 1-cycle-latency memory, in-order output scoreboard,
// and phases for fill, bus error, halt, flush drop, misaligned marker and resume.
module tb_ifu_ifetch_pf;

   localparam int PC_W    = 32;
   localparam int INSTR_W = 32;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [PC_W-1:0]    pc_rtvec;
   logic               ifu_req_valid, ifu_req_ready, ifu_req_seq;
   logic [PC_W-1:0]    ifu_req_pc, ifu_req_last_pc;
   logic               ifu_rsp_valid, ifu_rsp_ready, ifu_rsp_err;
   logic [INSTR_W-1:0] ifu_rsp_instr, ifu_o_ir;
   logic [PC_W-1:0]    ifu_o_pc;
   logic               ifu_o_buserr, ifu_o_misalgn, ifu_o_valid, ifu_o_ready;
   logic               pipe_flush_req, pipe_flush_ack;
   logic [PC_W-1:0]    pipe_flush_add_op1, pipe_flush_add_op2;
   logic               ifu_halt_req, ifu_halt_ack;

   ifu_ifetch_pf dut (
      .clk(clk), .rst_n(rst_n), .pc_rtvec(pc_rtvec),
      .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
      .ifu_req_seq(ifu_req_seq), .ifu_req_last_pc(ifu_req_last_pc),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_err(ifu_rsp_err),
      .ifu_rsp_instr(ifu_rsp_instr), .ifu_o_ir(ifu_o_ir), .ifu_o_pc(ifu_o_pc),
      .ifu_o_buserr(ifu_o_buserr), .ifu_o_misalgn(ifu_o_misalgn), .ifu_o_valid(ifu_o_valid),
      .ifu_o_ready(ifu_o_ready), .pipe_flush_req(pipe_flush_req), .pipe_flush_ack(pipe_flush_ack),
      .pipe_flush_add_op1(pipe_flush_add_op1), .pipe_flush_add_op2(pipe_flush_add_op2),
      .ifu_halt_req(ifu_halt_req), .ifu_halt_ack(ifu_halt_ack)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [INSTR_W-1:0] instr_of(input logic [PC_W-1:0] pc);
      return pc ^ 32'h1357_9BDF;
   endfunction

   // memory model state
   logic              mem_en;
   logic [PC_W-1:0]   err_pc;
   logic [PC_W-1:0]   pend_q[$];
   logic [PC_W-1:0]   req_pc_q[$];
   logic              req_seq_q[$];
   logic [PC_W+1:0]   exp_q[$];      // {pc, buserr, misalgn}
   int                last_rsp_edge = 0;
   logic              viol = 1'b0;

   // memory responder: answers each accepted request one cycle later, in order
   initial begin
      logic [PC_W-1:0] mpc;
      ifu_rsp_valid = 1'b0;
      ifu_rsp_err   = 1'b0;
      ifu_rsp_instr = '0;
      forever begin
         @(posedge clk);
         #2;
         if (mem_en && pend_q.size() > 0) begin
            mpc = pend_q.pop_front();
            ifu_rsp_valid = 1'b1;
            ifu_rsp_instr = instr_of(mpc);
            ifu_rsp_err   = (mpc == err_pc);
         end else begin
            ifu_rsp_valid = 1'b0;
            ifu_rsp_err   = 1'b0;
            ifu_rsp_instr = '0;
         end
      end
   end

   // monitors and output scoreboard, sampled mid-cycle
   initial begin
      logic [PC_W+1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && ifu_req_valid && ifu_req_ready) begin
            pend_q.push_back(ifu_req_pc);
            req_pc_q.push_back(ifu_req_pc);
            req_seq_q.push_back(ifu_req_seq);
         end
         if (ifu_rsp_valid && ifu_rsp_ready) last_rsp_edge = cyc + 1;
         if (dut.u_ibuf.push_i && dut.u_ibuf.full_o && !dut.u_ibuf.pop_i && !dut.u_ibuf.clr_i)
            viol = 1'b1;
         if (dut.u_ibuf.pop_i && dut.u_ibuf.empty_o) viol = 1'b1;
         if (ifu_o_valid && ifu_o_ready) begin
            if (exp_q.size() == 0) check("o_extra_entry", 64'(exp_q.size()), 64'd1);
            else begin
               e = exp_q.pop_front();
               check("o_pc",      ifu_o_pc, e[PC_W+1:2]);
               check("o_ir",      ifu_o_ir, e[0] ? '0 : instr_of(e[PC_W+1:2]));
               check("o_buserr",  ifu_o_buserr, e[1]);
               check("o_misalgn", ifu_o_misalgn, e[0]);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int n, input string tag);
      for (int i = 0; i < 40 && req_pc_q.size() < n; i++) step();
      check(tag, 64'(req_pc_q.size()), 64'(n));
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
      check(tag, 64'(exp_q.size()), 64'd0);
   endtask

   task automatic exp_push(input logic [PC_W-1:0] pc, input logic err, input logic mis);
      exp_q.push_back({pc, err, mis});
   endtask

   initial begin
      int ack_edge;
      rst_n = 1'b0; pc_rtvec = 32'h8000_0000; ifu_req_ready = 1'b1; ifu_o_ready = 1'b0;
      pipe_flush_req = 1'b0; pipe_flush_add_op1 = '0; pipe_flush_add_op2 = '0;
      ifu_halt_req = 1'b0; mem_en = 1'b1; err_pc = 32'h8000_0008;
      repeat (3) step();
      @(negedge clk);
      check("rst_req_valid", ifu_req_valid, 1'b0);
      check("rst_o_valid",   ifu_o_valid, 1'b0);
      check("rst_rsp_ready", ifu_rsp_ready, 1'b0);
      check("rst_halt_ack",  ifu_halt_ack, 1'b0);
      check("rst_flush_ack", pipe_flush_ack, 1'b1);
      check("rst_req_seq",   ifu_req_seq, 1'b0);
      check("rst_o_pc",      ifu_o_pc, 32'h0);
      step();
      rst_n = 1'b1;

      // fill with EXU stalled: exactly IBUF_DEPTH fetches, then issue stops
      repeat (15) step();
      @(negedge clk);
      check("fill_nreq", 64'(req_pc_q.size()), 64'd4);
      check("req0_pc", req_pc_q[0], 32'h8000_0000);
      check("req1_pc", req_pc_q[1], 32'h8000_0004);
      check("req2_pc", req_pc_q[2], 32'h8000_0008);
      check("req3_pc", req_pc_q[3], 32'h8000_000C);
      check("req0_seq", req_seq_q[0], 1'b0);
      check("req1_seq", req_seq_q[1], 1'b1);
      check("req2_seq", req_seq_q[2], 1'b1);
      check("fill_req_valid", ifu_req_valid, 1'b0);
      check("fill_last_pc", ifu_req_last_pc, 32'h8000_000C);
      check("fill_next_pc", ifu_req_pc, 32'h8000_0010);
      check("fill_head_pc", ifu_o_pc, 32'h8000_0000);
      check("fill_o_valid", ifu_o_valid, 1'b1);

      // halt, then drain in order; 0x8000_0008 carries the bus error
      step();
      ifu_halt_req = 1'b1; ifu_o_ready = 1'b1;
      exp_push(32'h8000_0000, 1'b0, 1'b0);
      exp_push(32'h8000_0004, 1'b0, 1'b0);
      exp_push(32'h8000_0008, 1'b1, 1'b0);
      exp_push(32'h8000_000C, 1'b0, 1'b0);
      wait_drain("drain_a");
      step(); step();
      @(negedge clk);
      check("drain_a_o_valid", ifu_o_valid, 1'b0);
      check("drain_a_halt_ack", ifu_halt_ack, 1'b1);
      check("drain_a_nreq", 64'(req_pc_q.size()), 64'd4);

      // resume, hold responses so two are outstanding, then halt
      step();
      mem_en = 1'b0; ifu_halt_req = 1'b0;
      wait_req(6, "resume_nreq");
      step();
      ifu_halt_req = 1'b1;
      @(negedge clk);
      check("halt_otf_ack", ifu_halt_ack, 1'b0);
      check("halt_req_valid", ifu_req_valid, 1'b0);
      check("req4_pc", req_pc_q[4], 32'h8000_0010);
      check("req4_seq", req_seq_q[4], 1'b1);
      check("req5_pc", req_pc_q[5], 32'h8000_0014);
      step();
      mem_en = 1'b1;
      exp_push(32'h8000_0010, 1'b0, 1'b0);
      exp_push(32'h8000_0014, 1'b0, 1'b0);
      ack_edge = -1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifu_halt_ack) begin
            ack_edge = cyc;
            break;
         end
      end
      check("halt_ack_seen", 64'(ack_edge >= 0), 64'd1);
      check("halt_ack_delay", 64'(ack_edge - last_rsp_edge), 64'd1);
      check("halt_nreq", 64'(req_pc_q.size()), 64'd6);
      step();
      wait_drain("drain_b");

      // release halt with request backpressure: pc must hold
      mem_en = 1'b0; ifu_req_ready = 1'b0; ifu_halt_req = 1'b0;
      @(negedge clk);
      check("hold_valid", ifu_req_valid, 1'b1);
      check("hold_pc0", ifu_req_pc, 32'h8000_0018);
      check("hold_seq", ifu_req_seq, 1'b1);
      step();
      @(negedge clk);
      check("hold_pc1", ifu_req_pc, 32'h8000_0018);
      step();
      ifu_req_ready = 1'b1;
      wait_req(8, "otf2_nreq");
      check("req6_pc", req_pc_q[6], 32'h8000_0018);
      check("req7_pc", req_pc_q[7], 32'h8000_001C);

      // flush with two in flight; target wraps modulo 2^32
      step();
      pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'hFFFF_FFF0; pipe_flush_add_op2 = 32'h8000_0110;
      ifu_o_ready = 1'b0;
      @(negedge clk);
      check("flush_req_valid", ifu_req_valid, 1'b0);
      check("flush_ack", pipe_flush_ack, 1'b1);
      step();
      pipe_flush_req = 1'b0; mem_en = 1'b1;
      wait_req(12, "flush_fill_nreq");
      repeat (10) step();
      @(negedge clk);
      check("flush_fill_nreq2", 64'(req_pc_q.size()), 64'd12);
      check("req8_pc", req_pc_q[8], 32'h8000_0100);
      check("req8_seq", req_seq_q[8], 1'b0);
      check("req9_seq", req_seq_q[9], 1'b1);
      check("flush_head_valid", ifu_o_valid, 1'b1);
      check("flush_head_pc", ifu_o_pc, 32'h8000_0100);
      check("flush_head_ir", ifu_o_ir, instr_of(32'h8000_0100));

      // misaligned target while buffer holds entries: buffer discarded, one marker
      step();
      pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h8000_0100; pipe_flush_add_op2 = 32'h2;
      ifu_o_ready = 1'b1;
      exp_push(32'h8000_0102, 1'b0, 1'b1);
      @(negedge clk);
      check("flush_masks_o_valid", ifu_o_valid, 1'b0);
      step();
      pipe_flush_req = 1'b0;
      wait_drain("marker");
      repeat (10) step();
      @(negedge clk);
      check("mis_nreq", 64'(req_pc_q.size()), 64'd12);
      check("mis_req_valid", ifu_req_valid, 1'b0);
      check("mis_o_valid", ifu_o_valid, 1'b0);

      // a new aligned flush releases the stall
      step();
      pipe_flush_req = 1'b1; pipe_flush_add_op1 = 32'h8000_0200; pipe_flush_add_op2 = 32'h0;
      ifu_o_ready = 1'b0;
      step();
      pipe_flush_req = 1'b0;
      wait_req(16, "realign_nreq");
      repeat (10) step();
      @(negedge clk);
      check("realign_nreq2", 64'(req_pc_q.size()), 64'd16);
      check("req12_pc", req_pc_q[12], 32'h8000_0200);
      check("req12_seq", req_seq_q[12], 1'b0);
      step();
      ifu_halt_req = 1'b1; ifu_o_ready = 1'b1;
      exp_push(32'h8000_0200, 1'b0, 1'b0);
      exp_push(32'h8000_0204, 1'b0, 1'b0);
      exp_push(32'h8000_0208, 1'b0, 1'b0);
      exp_push(32'h8000_020C, 1'b0, 1'b0);
      wait_drain("drain_e");
      step(); step();
      @(negedge clk);
      check("end_halt_ack", ifu_halt_ack, 1'b1);
      check("end_o_valid", ifu_o_valid, 1'b0);
      check("end_nreq", 64'(req_pc_q.size()), 64'd16);
      check("ibuf_ovf_udf", viol, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
